// File: rtl/csr_pkg.sv
// Shared CSR constants and the occupancy encoding used by the tohost queue.
package csr_pkg;

  localparam logic [11:0] CSR_TOHOST  = 12'h51E;
  localparam logic [11:0] CSR_CYCLE   = 12'hC00;
  localparam logic [11:0] CSR_INSTRET = 12'hC02;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  function automatic logic is_csr_write(input logic [2:0] funct3);
    return (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
  endfunction

endpackage

// File: rtl/csr_fifo.sv
// Generic DEPTH-entry FIFO; push lands one edge after request, pop head is a direct register read.
// Full blocks push and empty blocks pop internally; no same-cycle bypass when full.
module csr_fifo
  import csr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;
  occ_t             state;

  assign do_push = push && (state != OCC_FULL);
  assign do_pop  = pop && (state != OCC_EMPTY);

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  // Occupancy state is registered so full/empty come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= OCC_EMPTY;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (count_nxt == '0) begin
        state <= OCC_EMPTY;
      end else if (count_nxt == (AW+1)'(DEPTH)) begin
        state <= OCC_FULL;
      end else begin
        state <= OCC_PARTIAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (state == OCC_FULL);
  assign empty = (state == OCC_EMPTY);

endmodule

// File: rtl/csr_tohost_ctrl.sv
// tohost CSR write decode, host drain queue and cycle/instret counters; writes land one edge later.
// A tohost write while the queue is full raises csr_busy and waits; the host drains via valid/ready.
module csr_tohost_ctrl
  import csr_pkg::*;
#(
  parameter int          DEPTH       = 2,
  parameter logic [11:0] TOHOST_ADDR = CSR_TOHOST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        csr_req,
  input  logic [11:0] csr_addr,
  input  logic [2:0]  csr_funct3,
  input  logic [31:0] csr_rs1_data,
  input  logic [4:0]  csr_zimm,
  input  logic        inst_retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] csrd,
  output logic        csr_busy,
  output logic        host_valid,
  output logic [31:0] host_data,
  input  logic        host_ready
);

  logic                  wr_req;
  logic                  wr_acc;
  logic [31:0]           wdata;
  logic                  full;
  logic                  empty;
  logic [$clog2(DEPTH):0] unused_count;
  logic [31:0]           cycle_q;
  logic [31:0]           cycle_nxt;
  logic [31:0]           instret_q;

  assign wr_req     = csr_req && (csr_addr == TOHOST_ADDR) && is_csr_write(csr_funct3);
  assign wdata      = csr_funct3[2] ? {27'b0, csr_zimm} : csr_rs1_data;
  // Full blocks the push even if the host pops this cycle; the retry lands next edge.
  assign wr_acc     = wr_req && !stall && !full;
  assign csr_busy   = wr_req && full;
  assign host_valid = !empty;
  assign cycle_nxt  = cycle_q + 32'd1;

  csr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_acc),
    .pop   (host_valid && host_ready),
    .wdata (wdata),
    .rdata (host_data),
    .full  (full),
    .empty (empty),
    .count (unused_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      csrd      <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_nxt;
      if (inst_retire && !stall) instret_q <= instret_q + 32'd1;
      if (wr_acc) csrd <= wdata;
    end
  end

  always_comb begin
    csr_rdata = '0;
    if (csr_addr == TOHOST_ADDR) begin
      csr_rdata = csrd;
    end else if (csr_addr == CSR_CYCLE) begin
      csr_rdata = cycle_q;
    end else if (csr_addr == CSR_INSTRET) begin
      csr_rdata = instret_q;
    end
  end

endmodule

// File: tb/tb_csr_tohost_ctrl.sv
// Randomized bench: driver keeps a reference model and pushes accepted writes to a scoreboard;
// a separate monitor checks the host port against that scoreboard.
module tb_csr_tohost_ctrl;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [2:0]  csr_funct3;
  logic [31:0] csr_rs1_data;
  logic [4:0]  csr_zimm;
  logic        inst_retire;
  logic [31:0] csr_rdata;
  logic [31:0] csrd;
  logic        csr_busy;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mdl_csrd;
  logic [31:0] mdl_cycle;
  logic [31:0] mdl_instret;
  int          mdl_cnt;

  csr_tohost_ctrl #(
    .DEPTH       (DEPTH),
    .TOHOST_ADDR (12'h51E)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .csr_req      (csr_req),
    .csr_addr     (csr_addr),
    .csr_funct3   (csr_funct3),
    .csr_rs1_data (csr_rs1_data),
    .csr_zimm     (csr_zimm),
    .inst_retire  (inst_retire),
    .csr_rdata    (csr_rdata),
    .csrd         (csrd),
    .csr_busy     (csr_busy),
    .host_valid   (host_valid),
    .host_data    (host_data),
    .host_ready   (host_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model state advances at the posedge.
  task automatic step(input bit rst, input bit stl, input bit req, input logic [11:0] a,
                      input logic [2:0] f3, input logic [31:0] rs1, input logic [4:0] zi,
                      input bit ret, input bit rdy, input bit wrap);
    bit          m_wr;
    bit          m_acc;
    bit          m_pop;
    logic [31:0] m_wdata;
    logic [31:0] m_rd;
    @(negedge clk);
    reset = rst; stall = stl; csr_req = req; csr_addr = a; csr_funct3 = f3;
    csr_rs1_data = rs1; csr_zimm = zi; inst_retire = ret; host_ready = rdy;
    if (wrap) force dut.cycle_nxt = 32'hFFFF_FFFF;
    #1;
    m_wr    = req && (a == 12'h51E) && (f3 == 3'b001 || f3 == 3'b101);
    m_wdata = (f3 == 3'b101) ? {27'b0, zi} : rs1;
    case (a)
      12'h51E: m_rd = mdl_csrd;
      12'hC00: m_rd = mdl_cycle;
      12'hC02: m_rd = mdl_instret;
      default: m_rd = 32'h0;
    endcase
    check("csr_busy", {31'b0, csr_busy}, {31'b0, m_wr && mdl_cnt == DEPTH});
    check("host_valid", {31'b0, host_valid}, {31'b0, mdl_cnt != 0});
    check("csr_rdata", csr_rdata, m_rd);
    check("csrd", csrd, mdl_csrd);
    m_acc = m_wr && !stl && mdl_cnt < DEPTH;
    m_pop = rdy && mdl_cnt > 0;
    @(posedge clk);
    if (rst) begin
      mdl_csrd = 0; mdl_cycle = 0; mdl_instret = 0; mdl_cnt = 0;
      exp_q.delete();
    end else begin
      mdl_cycle = wrap ? 32'hFFFF_FFFF : mdl_cycle + 32'd1;
      if (ret && !stl) mdl_instret = mdl_instret + 32'd1;
      if (m_acc) begin
        mdl_csrd = m_wdata;
        exp_q.push_back(m_wdata);
        mdl_cnt++;
      end
      if (m_pop) mdl_cnt--;
    end
    if (wrap) begin
      #1;
      release dut.cycle_nxt;
    end
  endtask

  task automatic idle(input logic [11:0] a, input bit rdy);
    step(0, 0, 0, a, 3'b000, 32'h0, 5'h0, 0, rdy, 0);
  endtask

  task automatic wr(input bit stl, input logic [2:0] f3, input logic [31:0] rs1,
                    input logic [4:0] zi, input bit rdy);
    step(0, stl, 1, 12'h51E, f3, rs1, zi, 1, rdy, 0);
  endtask

  // Monitor: host_data must match the oldest accepted write whenever it is presented.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (host_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL host_unexpected: got valid data 0x%08h expected no entry at %0t", host_data, $time);
        end else begin
          check("host_data", host_data, exp_q[0]);
          if (host_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    mdl_csrd = 0; mdl_cycle = 0; mdl_instret = 0; mdl_cnt = 0;
    reset = 1; stall = 0; csr_req = 0; csr_addr = 0; csr_funct3 = 0;
    csr_rs1_data = 0; csr_zimm = 0; inst_retire = 0; host_ready = 0;

    // T1 reset
    step(1, 0, 0, 12'hC00, 3'b000, 0, 0, 0, 0, 0);
    step(1, 0, 0, 12'hC00, 3'b000, 0, 0, 0, 0, 0);
    idle(12'hC00, 0);

    // T2 csrrwi
    wr(0, 3'b101, 32'hFFFF_FFFF, 5'h11, 1);
    idle(12'h51E, 1);
    idle(12'h51E, 1);

    // T3 fill and hold, then drain with the blocked write retried
    wr(0, 3'b001, 32'hA, 0, 0);
    wr(0, 3'b001, 32'hB, 0, 0);
    wr(0, 3'b001, 32'hC, 0, 0);
    wr(0, 3'b001, 32'hC, 0, 1);
    wr(0, 3'b001, 32'hC, 0, 1);
    idle(12'hC02, 1);
    idle(12'hC00, 1);

    // T4 stall gating
    repeat (3) wr(1, 3'b001, 32'hDEAD_BEEF, 0, 1);
    idle(12'hC02, 0);
    wr(0, 3'b001, 32'hDEAD_BEEF, 0, 1);
    idle(12'hC00, 1);
    idle(12'hC02, 1);

    // T5 counter wrap and pointer wrap
    step(0, 0, 0, 12'hC00, 3'b000, 0, 0, 0, 1, 1);
    idle(12'hC00, 1);
    idle(12'hC00, 1);
    for (int i = 0; i < 5; i++) wr(0, 3'b001, 32'h100 + i, 0, 1);
    idle(12'h51E, 1);
    idle(12'h51E, 1);

    // T6 reset mid-drain
    wr(0, 3'b001, 32'h5A5A_0001, 0, 0);
    wr(0, 3'b001, 32'h5A5A_0002, 0, 0);
    step(1, 0, 0, 12'h51E, 3'b000, 0, 0, 0, 0, 0);
    idle(12'h51E, 1);
    idle(12'h51E, 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit          r_rst;
      logic [11:0] r_addr;
      logic [2:0]  r_f3;
      r_rst = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 4))
        0, 1:    r_addr = 12'h51E;
        2:       r_addr = 12'hC00;
        3:       r_addr = 12'hC02;
        default: r_addr = 12'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       r_f3 = 3'b001;
        1:       r_f3 = 3'b101;
        default: r_f3 = 3'($urandom);
      endcase
      step(r_rst, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, r_addr, r_f3,
           $urandom, 5'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 0);
    end

    repeat (DEPTH + 2) idle(12'hC00, 1);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
